pi_readout: RTL and testbench

- Serial transmitter on the Pi side of the capture buffer: the read end of the sample RAM.
- After the ADC capture path reports the buffer full, it blocks further capture and raises pi_signal_flag.
- It fetches bytes from the RAM read port and shifts them MSB-first on pi_data, clocked by Pi-driven pi_clk edges.
- pi_done from the Pi ends the transfer and re-arms capture.

---
 rtl/pi_readout.sv | 116 +++++++++++
 tb/tb_pi_readout.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pi_readout.sv
// pi_readout: streams the captured sample buffer MSB-first to the Pi on synchronized pi_clk edges.
module pi_readout #(
  parameter int DEPTH       = 25000,
  parameter int ADDR_W      = 15,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              osc_clk,
  input  logic              reset,
  input  logic              buf_full,
  input  logic              pi_clk,
  input  logic              pi_done,
  input  logic [DATA_W-1:0] rd_data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              capture_en,
  output logic              pi_signal_flag,
  output logic              pi_data
);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
  typedef enum logic [2:0] {IDLE, FETCH0, LOAD0, SHIFT, DRAIN} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] clk_sync, done_sync;
  logic clk_prev, done_prev, rd_pend, clk_rise, done_rise;
  logic [DATA_W-1:0] shift, hold;
  logic [BW-1:0] bit_cnt;
  logic [ADDR_W-1:0] byte_cnt;
  assign clk_rise  = clk_sync[SYNC_STAGES-1] & ~clk_prev;
  assign done_rise = done_sync[SYNC_STAGES-1] & ~done_prev;
  always_ff @(posedge osc_clk) begin
    if (reset) begin
      clk_sync  <= '0;
      done_sync <= '0;
      clk_prev  <= 1'b0;
      done_prev <= 1'b0;
    end else begin
      clk_sync  <= SYNC_STAGES'({clk_sync, pi_clk});
      done_sync <= SYNC_STAGES'({done_sync, pi_done});
      clk_prev  <= clk_sync[SYNC_STAGES-1];
      done_prev <= done_sync[SYNC_STAGES-1];
    end
  end
  always_ff @(posedge osc_clk) begin
    if (reset) begin
      state          <= IDLE;
      capture_en     <= 1'b1;
      pi_signal_flag <= 1'b0;
      pi_data        <= 1'b0;
      rd_en          <= 1'b0;
      rd_addr        <= '0;
      rd_pend        <= 1'b0;
      shift          <= '0;
      hold           <= '0;
      bit_cnt        <= '0;
      byte_cnt       <= '0;
    end else begin
      rd_pend <= rd_en;
      rd_en   <= 1'b0;
      if (rd_pend) hold <= rd_data;
      // pi_done outranks a coincident pi_clk rise
      if ((state == SHIFT || state == DRAIN) && done_rise) begin
        state          <= IDLE;
        capture_en     <= 1'b1;
        pi_signal_flag <= 1'b0;
        pi_data        <= 1'b0;
        rd_addr        <= '0;
        shift          <= '0;
        bit_cnt        <= '0;
        byte_cnt       <= '0;
      end else begin
        case (state)
          IDLE: if (buf_full) begin
            state      <= FETCH0;
            capture_en <= 1'b0;
            rd_en      <= 1'b1;
            rd_addr    <= '0;
          end
          FETCH0: state <= LOAD0;
          LOAD0: begin
            shift          <= rd_data;
            pi_data        <= rd_data[DATA_W-1];
            pi_signal_flag <= 1'b1;
            rd_en          <= DEPTH > 1;
            rd_addr        <= ADDR_W'(DEPTH > 1);
            state          <= SHIFT;
          end
          SHIFT: if (clk_rise) begin
            if (bit_cnt != LAST_BIT) begin
              shift   <= shift << 1;
              pi_data <= shift[DATA_W-2];
              bit_cnt <= bit_cnt + 1'b1;
            end else if (byte_cnt == LAST) begin
              state   <= DRAIN;
              pi_data <= 1'b0;
              shift   <= '0;
              bit_cnt <= '0;
            end else begin
              // seamless byte boundary: the prefetched byte is already in hold
              shift    <= hold;
              pi_data  <= hold[DATA_W-1];
              bit_cnt  <= '0;
              byte_cnt <= byte_cnt + 1'b1;
              if (rd_addr != LAST) begin
                rd_en   <= 1'b1;
                rd_addr <= rd_addr + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pi_readout.sv
// tb_pi_readout: randomized Pi-side transfers checked against a byte-stream model of the buffer.
module tb_pi_readout;
  localparam int DEPTH = 4, ADDR_W = 3, DATA_W = 8, SS = 2, PH = 10;
  logic osc_clk = 0, reset = 1, buf_full = 0, pi_clk = 0, pi_done = 0;
  logic [DATA_W-1:0] rd_data;
  logic rd_en, capture_en, pi_signal_flag, pi_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0] mem [DEPTH];
  logic [7:0] rx [DEPTH];
  logic [7:0] golden [DEPTH];
  int n_cmp = 0, n_bad = 0, rd_cnt = 0, fetch_idx = 0, bit_idx = 0;
  logic prev_rd_en = 0;

  pi_readout #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(SS)) dut (
    .osc_clk(osc_clk), .reset(reset), .buf_full(buf_full), .pi_clk(pi_clk), .pi_done(pi_done),
    .rd_data(rd_data), .rd_en(rd_en), .rd_addr(rd_addr), .capture_en(capture_en),
    .pi_signal_flag(pi_signal_flag), .pi_data(pi_data));

  always #5 osc_clk = ~osc_clk;
  always @(posedge osc_clk) if (rd_en) rd_data <= mem[rd_addr];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Every-cycle rules: no data without flag, fetches are single strobes at sequential addresses from 0.
  always @(negedge osc_clk) begin
    if (!pi_signal_flag) check("idle_data", pi_data, 0);
    else check("flag_blocks_capture", capture_en, 0);
    check("single_fetch", rd_en & prev_rd_en, 0);
    if (capture_en) fetch_idx = 0;
    if (rd_en) begin
      check("fetch_addr", rd_addr, fetch_idx);
      check("fetch_in_range", fetch_idx < DEPTH, 1);
      check("fetch_capture_off", capture_en, 0);
      fetch_idx++;
      rd_cnt++;
    end
    prev_rd_en = rd_en;
  end

  task automatic check_reset_vals();
    check("rst_capture", capture_en, 1);
    check("rst_flag", pi_signal_flag, 0);
    check("rst_data", pi_data, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_rd_addr", rd_addr, 0);
  endtask

  task automatic wait_flag(input logic v, input int lim, input string name);
    int n = 0;
    while (pi_signal_flag !== v && n < lim) begin
      @(negedge osc_clk);
      n++;
    end
    check(name, pi_signal_flag, v);
  endtask

  task automatic pi_pulse(input bit tog);
    logic exp;
    @(negedge osc_clk);
    exp = (bit_idx < DEPTH * DATA_W) ? mem[bit_idx / DATA_W][DATA_W - 1 - bit_idx % DATA_W] : 1'b0;
    if (pi_signal_flag) begin
      check("pi_bit", pi_data, exp);
      if (bit_idx < DEPTH * DATA_W) rx[bit_idx / DATA_W][DATA_W - 1 - bit_idx % DATA_W] = pi_data;
    end
    bit_idx++;
    pi_clk = 1;
    for (int i = 0; i < PH; i++) begin
      if (tog) buf_full = 1'($urandom_range(1));
      @(negedge osc_clk);
    end
    pi_clk = 0;
    if (tog) buf_full = 0;
    repeat (PH - 1) @(negedge osc_clk);
  endtask

  task automatic start_xfer(input bit keep);
    @(negedge osc_clk);
    buf_full = 1;
    @(negedge osc_clk);
    check("fetch0_rd_en", rd_en, 1);
    check("fetch0_addr", rd_addr, 0);
    check("fetch0_capture", capture_en, 0);
    if (!keep) buf_full = 0;
    wait_flag(1, 4, "flag_rise");
    bit_idx = 0;
    for (int i = 0; i < DEPTH; i++) rx[i] = 0;
  endtask

  task automatic done_pulse(input bit rearm);
    int n = 0;
    @(negedge osc_clk);
    pi_done = 1;
    while (!(pi_signal_flag === 0 && capture_en === 1) && n < SS + 2) begin
      @(negedge osc_clk);
      n++;
    end
    check("done_flag", pi_signal_flag, 0);
    check("done_capture", capture_en, 1);
    check("done_data", pi_data, 0);
    check("done_addr", rd_addr, 0);
    if (rearm) begin
      @(negedge osc_clk);
      check("rearm_rd_en", rd_en, 1);
      check("rearm_addr", rd_addr, 0);
      check("rearm_capture", capture_en, 0);
      buf_full = 0;
    end
    repeat (PH) @(negedge osc_clk);
    pi_done = 0;
    repeat (PH) @(negedge osc_clk);
  endtask

  task automatic rand_mem();
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c;
    golden[0] = 8'hA5; golden[1] = 8'h3C; golden[2] = 8'hFF; golden[3] = 8'h00;
    for (int i = 0; i < DEPTH; i++) mem[i] = golden[i];
    repeat (3) begin
      @(negedge osc_clk);
      check_reset_vals();
      buf_full = 1'($urandom_range(1));
      pi_clk = 1'($urandom_range(1));
      pi_done = 1'($urandom_range(1));
    end
    @(negedge osc_clk);
    reset = 0; buf_full = 0; pi_clk = 0; pi_done = 0;
    repeat (8) @(negedge osc_clk);

    c = rd_cnt;
    repeat (3) pi_pulse(0);
    check("idle_no_fetch", rd_cnt, c);
    check("idle_capture", capture_en, 1);

    c = rd_cnt;
    start_xfer(0);
    check("first_bit_msb", pi_data, 1);
    repeat (DEPTH * DATA_W) pi_pulse(0);
    for (int i = 0; i < DEPTH; i++) check("rx_byte_literal", rx[i], golden[i]);
    check("fetch_count", rd_cnt - c, DEPTH);
    repeat (5) @(negedge osc_clk);
    check("drain_flag", pi_signal_flag, 1);
    check("drain_data", pi_data, 0);
    c = rd_cnt;
    pi_pulse(0);
    repeat (PH) @(negedge osc_clk);
    check("drain_extra_clk_flag", pi_signal_flag, 1);
    check("drain_extra_clk_fetch", rd_cnt, c);
    done_pulse(0);

    rand_mem();
    c = rd_cnt;
    start_xfer(0);
    repeat (DATA_W + 3) pi_pulse(1);
    check("abort_fetches", rd_cnt - c, 3);
    done_pulse(0);
    c = rd_cnt;
    repeat (20) @(negedge osc_clk);
    check("abort_no_fetch", rd_cnt, c);

    for (int i = 0; i < DEPTH; i++) mem[i] = golden[i];
    start_xfer(0);
    @(negedge osc_clk);
    pi_clk = 1; pi_done = 1;
    repeat (SS + 4) begin
      @(negedge osc_clk);
      check("simul_no_shift", (pi_signal_flag && pi_data) || (!pi_signal_flag && !pi_data), 1);
    end
    check("simul_abort", pi_signal_flag, 0);
    repeat (PH) @(negedge osc_clk);
    pi_clk = 0; pi_done = 0;
    repeat (PH) @(negedge osc_clk);

    rand_mem();
    start_xfer(1);
    repeat (5) pi_pulse(0);
    rand_mem();
    done_pulse(1);
    wait_flag(1, 4, "rearm_flag");
    bit_idx = 0;
    for (int i = 0; i < DEPTH; i++) rx[i] = 0;
    repeat (DEPTH * DATA_W) pi_pulse(0);
    for (int i = 0; i < DEPTH; i++) check("rx_byte_model", rx[i], mem[i]);
    done_pulse(0);

    rand_mem();
    start_xfer(0);
    repeat (2 * DATA_W + 3) pi_pulse(0);
    @(negedge osc_clk);
    reset = 1;
    @(negedge osc_clk);
    check_reset_vals();
    reset = 0;
    repeat (5) @(negedge osc_clk);
    check("post_reset_capture", capture_en, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
